two_to_four_decoder_seq: RTL and testbench
==========================================

Name: two_to_four_decoder_seq

Overview:
Clocked 2-to-4 decoder. It is the receive-side counterpart of the team's 4-to-2 encoder: it takes the encoder's 2-bit code (E1,E0) and drives a registered one-hot output (Y3..Y0).
- Load mode: a code is accepted on a LOAD/READY handshake, and the matching output is held for a programmable number of cycles.
- Scan mode: the block cycles Y0 to Y3 automatically, for lab display/LED digit strobing.

Parameters:
HOLD_CYCLES, 4, cycles a loaded one-hot output stays asserted (legal range 1..255)
SCAN_DIV, 8, cycles each output stays asserted in scan mode (legal range 1..255)

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst  input  1  reset, synchronous, active-high
E0  input  1  code LSB (matches encoder output E0)
E1  input  1  code MSB (matches encoder output E1)
EN  input  1  output enable; 0 masks Y3..Y0 to 0 from the next edge, timing unaffected
LOAD  input  1  request to accept {E1,E0}; qualified by READY
SCAN  input  1  level; 1 selects auto-scan mode
READY  output  1  1 only in IDLE; LOAD is accepted when LOAD & READY & EN & !SCAN
Y0  output  1  one-hot bit for code 0
Y1  output  1  one-hot bit for code 1
Y2  output  1  one-hot bit for code 2
Y3  output  1  one-hot bit for code 3
BUSY  output  1  1 in HOLD or SCAN

Behaviour:
- All outputs are registered or decoded from registered state. No combinational path runs from the inputs to Y*.
- Reset: any edge with rst=1 gives state=IDLE, code=0, counter=0, scan index=0, Y3..Y0=0000, BUSY=0, READY=1.
  - rst overrides every other input.
  - rst mid-HOLD or mid-SCAN aborts immediately and Y clears the same edge.
- States: IDLE, HOLD, SCAN.
- IDLE:
  - Y=0000, READY=1.
  - SCAN=1: go to SCAN, index=0, counter=SCAN_DIV-1. SCAN has priority over LOAD in the same cycle.
  - Else LOAD & EN: latch code={E1,E0}, counter=HOLD_CYCLES-1, go to HOLD. Y becomes onehot(code) at that same edge.
  - LOAD with EN=0 is ignored; the block stays in IDLE.
- HOLD:
  - READY=0, BUSY=1, Y=onehot(code) & {4{EN}}.
  - Counter decrements each cycle. When the counter is 0, the next edge goes to IDLE and clears Y.
  - Net effect: Y is asserted for exactly HOLD_CYCLES cycles. HOLD_CYCLES=1 gives a single-cycle pulse.
  - LOAD, SCAN, E0 and E1 are ignored. A code change mid-hold does not alter Y.
- SCAN:
  - READY=0, BUSY=1, Y=onehot(index) & {4{EN}}.
  - Counter decrements. At 0: index increments and wraps 3 to 0, and the counter reloads SCAN_DIV-1.
  - SCAN=0 sampled at any edge: go to IDLE with Y=0000 at that edge. A partial slot is abandoned, and the index is reset to 0 on re-entry.
- Latency: a LOAD accepted at edge k makes Y visible in cycles k+1..k+HOLD_CYCLES. READY=1 again in cycle k+HOLD_CYCLES+1. Back-to-back accepts are therefore 1 idle cycle apart at minimum.
- Y is always one-hot or all-zero; two bits set at once is illegal.
- Counter width is 8 bits, with no overflow because parameters are limited to at most 255.
- EN toggling mid-HOLD or mid-SCAN masks or unmasks Y on the next edge only. Counter and index are unaffected.

Decomposition:
- Shared package `decoder_pkg`:
  - state encoding localparams: S_IDLE=2'd0, S_HOLD=2'd1, S_SCAN=2'd2
  - CNT_W=8
  - a onehot2to4 function: code to 4-bit one-hot
- One natural sub-module, `cycle_down_counter`:
  - loadable 8-bit down-counter with inputs load, load_value and enable, and a zero flag
  - shared by HOLD and SCAN

Test Plan:
- rst=1 for 2 edges with LOAD=1, SCAN=1 -> Y3..Y0=0000, READY=1, BUSY=0 throughout; after release with SCAN=0, LOAD=0, the block stays IDLE.
- HOLD_CYCLES=4, E1E0=10, LOAD=1 for one cycle at edge k -> Y=0100 in cycles k+1..k+4, 0000 at k+5, READY=0 for k+1..k+4; changing E1E0 to 01 mid-hold leaves Y=0100.
- Sweep codes 00,01,10,11 back-to-back, LOAD held high -> successive pulses Y=0001,0010,0100,1000, each 4 cycles, one IDLE cycle between, never two bits set.
- SCAN=1 with SCAN_DIV=8 for 40 cycles -> Y sequence 0001,0010,0100,1000,0001, each for 8 cycles; SCAN=0 mid-slot -> Y=0000 next edge, READY=1.
- EN=0 with LOAD=1 in IDLE -> no accept, READY stays 1; EN dropped for 2 cycles mid-HOLD -> Y=0000 for those cycles, and hold still ends on schedule.
- rst pulsed 2 cycles into a HOLD, and separately in SCAN index 2 -> Y=0000 at that edge, state IDLE, next SCAN restarts at Y=0001.

Source files
------------

// File: rtl/decoder_pkg.sv
// =============================================================================
// Module  : decoder_pkg
// Brief   : Shared state encodings, counter width and code-to-one-hot helper.
// Rev     : 1.0
// =============================================================================
`default_nettype none

package decoder_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;

  function automatic logic [3:0] onehot2to4(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_down_counter.sv
// =============================================================================
// Module  : cycle_down_counter
// Brief   : Loadable down-counter that saturates at zero, with a zero flag.
// Rev     : 1.0
// =============================================================================
`default_nettype none

module cycle_down_counter
  import decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_value_i,
  input  logic             enable_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_value_i;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/two_to_four_decoder_seq.sv
// =============================================================================
// Module  : two_to_four_decoder_seq
// Brief   : Clocked 2-to-4 decoder with timed load/hold and auto-scan modes.
// Rev     : 1.0
// =============================================================================
`default_nettype none

module two_to_four_decoder_seq
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int SCAN_DIV    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic E0,
  input  logic E1,
  input  logic EN,
  input  logic LOAD,
  input  logic SCAN,
  output logic READY,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic BUSY
);

  localparam logic [CNT_W-1:0] c_HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_SCAN_RELOAD = CNT_W'(SCAN_DIV - 1);

  logic [1:0] state_q;
  logic [1:0] code_q;
  logic [1:0] idx_q;
  logic [3:0] y_q;

  logic             w_accept;
  logic             w_scan_start;
  logic             w_scan_wrap;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_cnt_value;

  // Counter controls look only at the current edge's inputs; Y stays registered.
  assign w_scan_start = (state_q == S_IDLE) && SCAN;
  assign w_accept     = (state_q == S_IDLE) && !SCAN && LOAD && EN;
  assign w_scan_wrap  = (state_q == S_SCAN) && SCAN && w_cnt_zero;
  assign w_cnt_load   = w_scan_start || w_accept || w_scan_wrap;
  assign w_cnt_value  = w_accept ? c_HOLD_RELOAD : c_SCAN_RELOAD;
  assign w_cnt_en     = (state_q == S_HOLD) || (state_q == S_SCAN);

  cycle_down_counter u_cnt (
    .clk          (clk),
    .rst          (rst),
    .load_i       (w_cnt_load),
    .load_value_i (w_cnt_value),
    .enable_i     (w_cnt_en),
    .zero_o       (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= 2'd0;
      idx_q   <= 2'd0;
      y_q     <= 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (SCAN) begin
            state_q <= S_SCAN;
            idx_q   <= 2'd0;
            y_q     <= onehot2to4(2'd0) & {4{EN}};
          end else if (LOAD && EN) begin
            state_q <= S_HOLD;
            code_q  <= {E1, E0};
            y_q     <= onehot2to4({E1, E0});
          end else begin
            y_q <= 4'b0000;
          end
        end
        S_HOLD: begin
          if (w_cnt_zero) begin
            state_q <= S_IDLE;
            y_q     <= 4'b0000;
          end else begin
            y_q <= onehot2to4(code_q) & {4{EN}};
          end
        end
        S_SCAN: begin
          if (!SCAN) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            y_q     <= 4'b0000;
          end else if (w_cnt_zero) begin
            idx_q <= idx_q + 2'd1;
            y_q   <= onehot2to4(idx_q + 2'd1) & {4{EN}};
          end else begin
            y_q <= onehot2to4(idx_q) & {4{EN}};
          end
        end
        default: begin
          state_q <= S_IDLE;
          y_q     <= 4'b0000;
        end
      endcase
    end
  end

  assign READY = (state_q == S_IDLE);
  assign BUSY  = (state_q == S_HOLD) || (state_q == S_SCAN);
  assign Y0    = y_q[0];
  assign Y1    = y_q[1];
  assign Y2    = y_q[2];
  assign Y3    = y_q[3];

endmodule

`default_nettype wire

// File: tb/tb_two_to_four_decoder_seq.sv
// =============================================================================
// Module  : tb_two_to_four_decoder_seq
// Brief   : Directed vector table plus hand sequences for the clocked decoder.
// Rev     : 1.0
// =============================================================================
`default_nettype none

module tb_two_to_four_decoder_seq;

  logic clk = 1'b0;
  logic rst, E0, E1, EN, LOAD, SCAN;
  logic READY, Y0, Y1, Y2, Y3, BUSY;

  int errors = 0;
  int checks = 0;

  two_to_four_decoder_seq #(.HOLD_CYCLES(4), .SCAN_DIV(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .E0    (E0),
    .E1    (E1),
    .EN    (EN),
    .LOAD  (LOAD),
    .SCAN  (SCAN),
    .READY (READY),
    .Y0    (Y0),
    .Y1    (Y1),
    .Y2    (Y2),
    .Y3    (Y3),
    .BUSY  (BUSY)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [1:0] e;
    logic       en;
    logic       load;
    logic       scan;
    logic [3:0] y;
    logic       rdy;
    logic       bsy;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic [1:0] e, input logic en,
                              input logic ld, input logic sc, input logic [3:0] y,
                              input logic rdy, input logic bsy);
    vec_t v;
    v.rst = r; v.e = e; v.en = en; v.load = ld; v.scan = sc;
    v.y = y; v.rdy = rdy; v.bsy = bsy;
    return v;
  endfunction

  // Inputs are applied just after an edge; outputs are sampled 1 time unit after the next edge.
  task automatic step(input logic r, input logic [1:0] e, input logic en,
                      input logic ld, input logic sc);
    rst = r; E1 = e[1]; E0 = e[0]; EN = en; LOAD = ld; SCAN = sc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] ey, input logic erdy,
                       input logic ebsy);
    logic [3:0] ay;
    ay = {Y3, Y2, Y1, Y0};
    checks++;
    if (ay !== ey || READY !== erdy || BUSY !== ebsy || $countones(ay) > 1) begin
      errors++;
      $display("FAIL %s: got Y=%b READY=%b BUSY=%b, want Y=%b READY=%b BUSY=%b",
               name, ay, READY, BUSY, ey, erdy, ebsy);
    end
  endtask

  initial begin
    logic [3:0] exp_y;

    rst = 1'b1; E0 = 1'b0; E1 = 1'b0; EN = 1'b1; LOAD = 1'b0; SCAN = 1'b0;

    //                 rst  e     en  ld  sc  y        rdy bsy
    vecs[0]  = mk(1, 2'd3, 1, 1, 1, 4'b0000, 1, 0);  // reset overrides LOAD/SCAN
    vecs[1]  = mk(1, 2'd3, 1, 1, 1, 4'b0000, 1, 0);
    vecs[2]  = mk(0, 2'd0, 1, 0, 0, 4'b0000, 1, 0);
    vecs[3]  = mk(0, 2'd0, 1, 0, 0, 4'b0000, 1, 0);
    vecs[4]  = mk(0, 2'd2, 1, 1, 0, 4'b0100, 0, 1);  // accept code 2
    vecs[5]  = mk(0, 2'd1, 1, 0, 0, 4'b0100, 0, 1);  // code change ignored
    vecs[6]  = mk(0, 2'd1, 1, 0, 0, 4'b0100, 0, 1);
    vecs[7]  = mk(0, 2'd1, 1, 0, 0, 4'b0100, 0, 1);
    vecs[8]  = mk(0, 2'd1, 1, 0, 0, 4'b0000, 1, 0);  // hold over after 4 cycles
    vecs[9]  = mk(0, 2'd3, 0, 1, 0, 4'b0000, 1, 0);  // LOAD with EN=0 ignored
    vecs[10] = mk(0, 2'd3, 0, 1, 0, 4'b0000, 1, 0);
    vecs[11] = mk(0, 2'd3, 1, 1, 0, 4'b1000, 0, 1);  // accept code 3
    vecs[12] = mk(0, 2'd3, 0, 0, 0, 4'b0000, 0, 1);  // EN masks Y
    vecs[13] = mk(0, 2'd3, 0, 0, 0, 4'b0000, 0, 1);
    vecs[14] = mk(0, 2'd3, 1, 0, 0, 4'b1000, 0, 1);  // unmasked, last hold cycle
    vecs[15] = mk(0, 2'd3, 1, 0, 0, 4'b0000, 1, 0);  // ends on schedule
    vecs[16] = mk(0, 2'd0, 1, 1, 0, 4'b0001, 0, 1);  // accept code 0
    vecs[17] = mk(0, 2'd3, 1, 1, 1, 4'b0001, 0, 1);  // LOAD/SCAN ignored in HOLD
    vecs[18] = mk(0, 2'd3, 1, 0, 1, 4'b0001, 0, 1);
    vecs[19] = mk(0, 2'd3, 1, 0, 1, 4'b0001, 0, 1);
    vecs[20] = mk(0, 2'd3, 1, 0, 0, 4'b0000, 1, 0);
    vecs[21] = mk(0, 2'd3, 1, 1, 1, 4'b0001, 0, 1);  // SCAN beats LOAD
    vecs[22] = mk(0, 2'd3, 1, 0, 0, 4'b0000, 1, 0);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].e, vecs[i].en, vecs[i].load, vecs[i].scan);
      check($sformatf("vec%0d", i), vecs[i].y, vecs[i].rdy, vecs[i].bsy);
    end

    // Back-to-back code sweep with LOAD held high: 4 hold cycles then 1 idle cycle each.
    for (int c = 0; c < 4; c++) begin
      exp_y = 4'b0001 << c;
      for (int k = 0; k < 4; k++) begin
        step(1'b0, 2'(c), 1'b1, 1'b1, 1'b0);
        check($sformatf("sweep_c%0d_k%0d", c, k), exp_y, 1'b0, 1'b1);
      end
      step(1'b0, 2'(c), 1'b1, 1'b1, 1'b0);
      check($sformatf("sweep_c%0d_idle", c), 4'b0000, 1'b1, 1'b0);
    end

    // Auto-scan for 40 cycles, 8 cycles per slot, wrapping back to Y0.
    for (int i = 0; i < 40; i++) begin
      exp_y = 4'b0001 << ((i / 8) % 4);
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
      check($sformatf("scan_%0d", i), exp_y, 1'b0, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
      check($sformatf("scan_tail_%0d", i), 4'b0010, 1'b0, 1'b1);
    end
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    check("scan_abort", 4'b0000, 1'b1, 1'b0);

    // Reset two cycles into a HOLD.
    step(1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    check("rsthold_1", 4'b0010, 1'b0, 1'b1);
    step(1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    check("rsthold_2", 4'b0010, 1'b0, 1'b1);
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    check("rsthold_rst", 4'b0000, 1'b1, 1'b0);
    step(1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    check("rsthold_idle", 4'b0000, 1'b1, 1'b0);

    // Reset while scanning slot index 2, then scan restarts at Y0.
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    end
    check("rstscan_idx2", 4'b0100, 1'b0, 1'b1);
    step(1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    check("rstscan_rst", 4'b0000, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    check("rstscan_restart", 4'b0001, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    check("rstscan_exit", 4'b0000, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
